// File: rtl/sr_flipflop.sv
`default_nettype none
// ============================================================================
//  Module      : sr_flipflop
//  Description : Bank of WIDTH independent clocked set/reset flip-flops with
//                complementary outputs and a per-bit S=R=1 flag.
//                Each bit updates on the rising edge of clk from its own
//                s/r pair. The S=R=1 case resolves through INVALID_MODE
//                and raises invalid[i] for one cycle.
//
//  Parameters  : WIDTH        - number of independent SR bits
//                RST_VAL      - value loaded into q while rst is high
//                INVALID_MODE - S=R=1 resolution: 0 reset-dominant,
//                               1 set-dominant, 2 hold, 3 toggle
//                               (any other value behaves as 0)
//
//  Ports       : clk     in   clock, rising-edge active
//                rst     in   asynchronous reset, active-high
//                s       in   [WIDTH] set request per bit
//                r       in   [WIDTH] reset request per bit
//                q       out  [WIDTH] registered state
//                q_bar   out  [WIDTH] bitwise complement of q
//                invalid out  [WIDTH] bit saw S=R=1 at the last edge
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_flipflop #(
    parameter int               WIDTH        = 1,
    parameter logic [WIDTH-1:0] RST_VAL      = '0,
    parameter int               INVALID_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] invalid
);

    // Resolution policy encodings for the S=R=1 case.
    localparam logic [1:0] c_MODE_RESET  = 2'd0;
    localparam logic [1:0] c_MODE_SET    = 2'd1;
    localparam logic [1:0] c_MODE_HOLD   = 2'd2;
    localparam logic [1:0] c_MODE_TOGGLE = 2'd3;

    // Out-of-range policy values fall back to reset-dominant so the S=R=1
    // case always has a defined result.
    localparam logic [1:0] c_MODE_SEL =
        ((INVALID_MODE >= 0) && (INVALID_MODE <= 3)) ? 2'(INVALID_MODE)
                                                     : c_MODE_RESET;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_invalid;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_invalid_next;
    logic [WIDTH-1:0] w_q_conflict;

    // Value every bit takes when it sees S=R=1, computed for the whole bank.
    always_comb begin
        w_q_conflict = '0;
        case (c_MODE_SEL)
            c_MODE_RESET:  w_q_conflict = '0;
            c_MODE_SET:    w_q_conflict = '1;
            c_MODE_HOLD:   w_q_conflict = r_q;
            c_MODE_TOGGLE: w_q_conflict = ~r_q;
        endcase
    end

    // Per-bit next-state decode; bits are fully independent.
    always_comb begin
        w_q_next       = r_q;
        w_invalid_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case ({s[i], r[i]})
                2'b00: w_q_next[i] = r_q[i];
                2'b01: w_q_next[i] = 1'b0;
                2'b10: w_q_next[i] = 1'b1;
                2'b11: begin
                    w_q_next[i]       = w_q_conflict[i];
                    w_invalid_next[i] = 1'b1;
                end
            endcase
        end
    end

    // Single state register; reset wins over any edge in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= RST_VAL;
            r_invalid <= '0;
        end else begin
            r_q       <= w_q_next;
            r_invalid <= w_invalid_next;
        end
    end

    // q_bar is derived from the same register so q and q_bar never agree.
    assign q       = r_q;
    assign q_bar   = ~r_q;
    assign invalid = r_invalid;

endmodule
`default_nettype wire

// File: tb/tb_sr_flipflop.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_flipflop
//  Description : Directed self-checking bench for sr_flipflop. Five 1-bit
//                instances (modes 0,1,2,3 and out-of-range 7) share s1/r1;
//                one 4-bit instance with RST_VAL=4'b0101 uses s4/r4.
//                Inputs change on the falling edge, outputs are sampled
//                1 ns after the rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_flipflop;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s1  = 1'b0;
    logic       r1  = 1'b0;
    logic [3:0] s4  = 4'b0000;
    logic [3:0] r4  = 4'b0000;

    logic q0, qb0, iv0;
    logic q1, qb1, iv1;
    logic q2, qb2, iv2;
    logic q3, qb3, iv3;
    logic q7, qb7, iv7;
    logic [3:0] q4, qb4, iv4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sr_flipflop #(.WIDTH(1), .INVALID_MODE(0)) dut_m0 (
        .clk(clk), .rst(rst), .s(s1), .r(r1), .q(q0), .q_bar(qb0), .invalid(iv0));
    sr_flipflop #(.WIDTH(1), .INVALID_MODE(1)) dut_m1 (
        .clk(clk), .rst(rst), .s(s1), .r(r1), .q(q1), .q_bar(qb1), .invalid(iv1));
    sr_flipflop #(.WIDTH(1), .INVALID_MODE(2)) dut_m2 (
        .clk(clk), .rst(rst), .s(s1), .r(r1), .q(q2), .q_bar(qb2), .invalid(iv2));
    sr_flipflop #(.WIDTH(1), .INVALID_MODE(3)) dut_m3 (
        .clk(clk), .rst(rst), .s(s1), .r(r1), .q(q3), .q_bar(qb3), .invalid(iv3));
    sr_flipflop #(.WIDTH(1), .INVALID_MODE(7)) dut_m7 (
        .clk(clk), .rst(rst), .s(s1), .r(r1), .q(q7), .q_bar(qb7), .invalid(iv7));
    sr_flipflop #(.WIDTH(4), .RST_VAL(4'b0101), .INVALID_MODE(0)) dut_w4 (
        .clk(clk), .rst(rst), .s(s4), .r(r4), .q(q4), .q_bar(qb4), .invalid(iv4));

    // Drive the shared 1-bit pair on a falling edge, then sample after the
    // following rising edge.
    task automatic apply1(input logic sv, input logic rv);
        @(negedge clk);
        s1 = sv;
        r1 = rv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s1 = 1'b0; r1 = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (q0 !== 1'b0)  begin n_err++; $display("FAIL reset_q: got %b want 0", q0); end
        n_cmp++; if (qb0 !== 1'b1) begin n_err++; $display("FAIL reset_qbar: got %b want 1", qb0); end
        n_cmp++; if (iv0 !== 1'b0) begin n_err++; $display("FAIL reset_invalid: got %b want 0", iv0); end
        n_cmp++; if (q4 !== 4'b0101)  begin n_err++; $display("FAIL reset_q4: got %b want 0101", q4); end
        n_cmp++; if (qb4 !== 4'b1010) begin n_err++; $display("FAIL reset_qbar4: got %b want 1010", qb4); end
        // s/r ignored while reset is held
        apply1(1'b1, 1'b0);
        n_cmp++; if (q0 !== 1'b0) begin n_err++; $display("FAIL reset_hold_ignores_s: got %b want 0", q0); end
    endtask

    task automatic test_release();
        @(negedge clk);
        rst = 1'b0; s1 = 1'b0; r1 = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (q0 !== 1'b0)  begin n_err++; $display("FAIL release_hold_q: got %b want 0", q0); end
        n_cmp++; if (qb0 !== 1'b1) begin n_err++; $display("FAIL release_hold_qbar: got %b want 1", qb0); end
    endtask

    task automatic test_set_reset();
        apply1(1'b0, 1'b1);
        n_cmp++; if (q0 !== 1'b0)  begin n_err++; $display("FAIL r_only_q: got %b want 0", q0); end
        n_cmp++; if (qb0 !== 1'b1) begin n_err++; $display("FAIL r_only_qbar: got %b want 1", qb0); end
        apply1(1'b1, 1'b0);
        n_cmp++; if (q0 !== 1'b1)  begin n_err++; $display("FAIL s_only_q: got %b want 1", q0); end
        n_cmp++; if (qb0 !== 1'b0) begin n_err++; $display("FAIL s_only_qbar: got %b want 0", qb0); end
        n_cmp++; if (iv0 !== 1'b0) begin n_err++; $display("FAIL s_only_invalid: got %b want 0", iv0); end
        apply1(1'b0, 1'b0);
        n_cmp++; if (q0 !== 1'b1) begin n_err++; $display("FAIL hold_one_q: got %b want 1", q0); end
    endtask

    task automatic test_invalid_default();
        // q=1 in every 1-bit instance here
        apply1(1'b1, 1'b1);
        n_cmp++; if (q0 !== 1'b0)  begin n_err++; $display("FAIL sr11_m0_q: got %b want 0", q0); end
        n_cmp++; if (qb0 !== 1'b1) begin n_err++; $display("FAIL sr11_m0_qbar: got %b want 1", qb0); end
        n_cmp++; if (iv0 !== 1'b1) begin n_err++; $display("FAIL sr11_m0_invalid: got %b want 1", iv0); end
        n_cmp++; if (q7 !== 1'b0)  begin n_err++; $display("FAIL sr11_m7_q: got %b want 0", q7); end
        n_cmp++; if (iv7 !== 1'b1) begin n_err++; $display("FAIL sr11_m7_invalid: got %b want 1", iv7); end
        apply1(1'b0, 1'b0);
        n_cmp++; if (iv0 !== 1'b0) begin n_err++; $display("FAIL invalid_clears: got %b want 0", iv0); end
        n_cmp++; if (q0 !== 1'b0)  begin n_err++; $display("FAIL invalid_clears_q: got %b want 0", q0); end
    endtask

    task automatic test_modes();
        apply1(1'b0, 1'b1);   // all 1-bit instances to q=0
        apply1(1'b1, 1'b1);
        n_cmp++; if (q1 !== 1'b1) begin n_err++; $display("FAIL m1_edge1_q: got %b want 1", q1); end
        n_cmp++; if (q2 !== 1'b0) begin n_err++; $display("FAIL m2_edge1_q: got %b want 0", q2); end
        n_cmp++; if (q3 !== 1'b1) begin n_err++; $display("FAIL m3_edge1_q: got %b want 1", q3); end
        n_cmp++; if (iv3 !== 1'b1) begin n_err++; $display("FAIL m3_edge1_invalid: got %b want 1", iv3); end
        apply1(1'b1, 1'b1);
        n_cmp++; if (q1 !== 1'b1) begin n_err++; $display("FAIL m1_edge2_q: got %b want 1", q1); end
        n_cmp++; if (q2 !== 1'b0) begin n_err++; $display("FAIL m2_edge2_q: got %b want 0", q2); end
        n_cmp++; if (q3 !== 1'b0) begin n_err++; $display("FAIL m3_edge2_q: got %b want 0", q3); end
        n_cmp++; if (qb3 !== 1'b1) begin n_err++; $display("FAIL m3_edge2_qbar: got %b want 1", qb3); end
        n_cmp++; if (qb1 !== 1'b0) begin n_err++; $display("FAIL m1_edge2_qbar: got %b want 0", qb1); end
        apply1(1'b0, 1'b0);
        n_cmp++; if (iv1 !== 1'b0) begin n_err++; $display("FAIL m1_invalid_clears: got %b want 0", iv1); end
    endtask

    task automatic test_no_transparency();
        // q0=0 here; pulse s between edges only
        @(negedge clk);
        s1 = 1'b1; r1 = 1'b0;
        #2;
        n_cmp++; if (q0 !== 1'b0) begin n_err++; $display("FAIL no_transp_mid: got %b want 0", q0); end
        s1 = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (q0 !== 1'b0) begin n_err++; $display("FAIL no_transp_edge: got %b want 0", q0); end
    endtask

    task automatic test_width4();
        // q4=0101: bit3 set, bit2 reset, bit1 S=R=1 (reset-dominant), bit0 hold
        @(negedge clk);
        s4 = 4'b1010; r4 = 4'b0110;
        @(posedge clk); #1;
        n_cmp++; if (q4 !== 4'b1001)  begin n_err++; $display("FAIL w4_q: got %b want 1001", q4); end
        n_cmp++; if (qb4 !== 4'b0110) begin n_err++; $display("FAIL w4_qbar: got %b want 0110", qb4); end
        n_cmp++; if (iv4 !== 4'b0010) begin n_err++; $display("FAIL w4_invalid: got %b want 0010", iv4); end
        @(negedge clk);
        s4 = 4'b0000; r4 = 4'b0000;
        @(posedge clk); #1;
        n_cmp++; if (iv4 !== 4'b0000) begin n_err++; $display("FAIL w4_invalid_clears: got %b want 0000", iv4); end
        n_cmp++; if (q4 !== 4'b1001)  begin n_err++; $display("FAIL w4_hold: got %b want 1001", q4); end
    endtask

    task automatic test_async_reset();
        apply1(1'b1, 1'b0);
        n_cmp++; if (q0 !== 1'b1) begin n_err++; $display("FAIL pre_async_q: got %b want 1", q0); end
        // Assert reset midway between edges with a set request pending
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (q0 !== 1'b0)  begin n_err++; $display("FAIL async_q: got %b want 0", q0); end
        n_cmp++; if (qb0 !== 1'b1) begin n_err++; $display("FAIL async_qbar: got %b want 1", qb0); end
        n_cmp++; if (q4 !== 4'b0101) begin n_err++; $display("FAIL async_q4: got %b want 0101", q4); end
        @(posedge clk); #1;
        n_cmp++; if (q0 !== 1'b0) begin n_err++; $display("FAIL async_held_q: got %b want 0", q0); end
        // Release; first rising edge with rst low takes the set
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (q0 !== 1'b1) begin n_err++; $display("FAIL post_release_q: got %b want 1", q0); end
    endtask

    initial begin
        test_reset();
        test_release();
        test_set_reset();
        test_invalid_default();
        test_modes();
        test_no_transparency();
        test_width4();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
